// File: rtl/decode_operand_stage_if.sv
// Handshake/bus bundle between the fetch side, the decode/operand stage and the ALU.
// The slave modport is the stage's view; the master modport is the surrounding pipeline's view.
interface decode_operand_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_in_A;
  logic [31:0] alu_in_B;
  logic [2:0]  func;
  logic        control;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, alu_in_A, alu_in_B, func, control, out_rd, out_rd_we, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, alu_in_A, alu_in_B, func, control, out_rd, out_rd_we, out_illegal
  );
endinterface

// File: rtl/decode_operand_stage.sv
// Decode/operand-fetch stage: RV32I OP/OP-IMM/LUI/AUIPC decode, 32x32 register file,
// writeback bypass, and one registered ALU bundle behind a valid/ready handshake.
module decode_operand_stage #(
  parameter int unsigned XLEN      = 32,
  parameter bit          BYPASS_EN = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  decode_operand_stage_if.slave bus
);
  localparam int unsigned NREG = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned FW   = 3;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  logic [XLEN-1:0] regs [NREG];

  logic [6:0]      opcode;
  logic [FW-1:0]   funct3;
  logic [6:0]      funct7;
  logic [RW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] rs1_val, rs2_val, u_imm;
  logic            funct7_ok;
  logic            capture;

  logic [XLEN-1:0] dec_a, dec_b;
  logic [FW-1:0]   dec_func;
  logic            dec_ctrl, dec_legal;

  logic            valid_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [FW-1:0]   func_q;
  logic            ctrl_q, we_q, ill_q;
  logic [RW-1:0]   rd_q;

  assign opcode = bus.in_instr[6:0];
  assign rd     = bus.in_instr[11:7];
  assign funct3 = bus.in_instr[14:12];
  assign rs1    = bus.in_instr[19:15];
  assign rs2    = bus.in_instr[24:20];
  assign funct7 = bus.in_instr[31:25];
  assign u_imm  = {bus.in_instr[31:12], 12'b0};

  // Only SRA/SRAI may set bit 30; SUB is rejected because the ALU cannot subtract.
  assign funct7_ok = (funct7 == 7'b0000000) || ((funct7 == 7'b0100000) && (funct3 == 3'b101));

  // Operand read with x0 hardwired and optional same-cycle writeback forwarding.
  assign rs1_val = (rs1 == '0) ? '0
                 : (BYPASS_EN && bus.wb_en && (bus.wb_rd == rs1)) ? bus.wb_data
                 : regs[rs1];
  assign rs2_val = (rs2 == '0) ? '0
                 : (BYPASS_EN && bus.wb_en && (bus.wb_rd == rs2)) ? bus.wb_data
                 : regs[rs2];

  always_comb begin
    dec_a     = '0;
    dec_b     = '0;
    dec_func  = '0;
    dec_ctrl  = 1'b0;
    dec_legal = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        dec_legal = funct7_ok;
        dec_a     = rs1_val;
        dec_b     = rs2_val;
        dec_func  = funct3;
        dec_ctrl  = (funct3 == 3'b101) ? bus.in_instr[30] : 1'b0;
      end
      OPC_OPIMM: begin
        dec_a    = rs1_val;
        dec_func = funct3;
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          dec_legal = funct7_ok;
          dec_b     = XLEN'(bus.in_instr[24:20]);
          dec_ctrl  = (funct3 == 3'b101) ? bus.in_instr[30] : 1'b0;
        end else begin
          dec_legal = 1'b1;
          dec_b     = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
        end
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_a     = u_imm;
        dec_ctrl  = 1'b1;
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_a     = bus.in_pc;
        dec_b     = u_imm;
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_a    = '0;
      dec_b    = '0;
      dec_func = '0;
      dec_ctrl = 1'b0;
    end
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready;

  // Register file writes are independent of stall and flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (bus.wb_en && (bus.wb_rd != '0)) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Output bundle; flush wins over a same-cycle capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      func_q  <= '0;
      ctrl_q  <= 1'b0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      a_q     <= dec_a;
      b_q     <= dec_b;
      func_q  <= dec_func;
      ctrl_q  <= dec_ctrl;
      rd_q    <= rd;
      we_q    <= dec_legal && (rd != '0);
      ill_q   <= !dec_legal;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.alu_in_A    = a_q;
  assign bus.alu_in_B    = b_q;
  assign bus.func        = func_q;
  assign bus.control     = ctrl_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_rd_we   = we_q;
  assign bus.out_illegal = ill_q;
endmodule

// File: tb/tb_decode_operand_stage.sv
// Bench for decode_operand_stage: vector table fed through a scoreboard, plus
// hand-written stall, bypass, flush and reset sequences. u1 is a no-bypass copy.
module tb_decode_operand_stage;
  logic clk;
  logic rst;

  decode_operand_stage_if bus ();
  decode_operand_stage_if bus1 ();

  decode_operand_stage #(.XLEN(32), .BYPASS_EN(1'b1)) u0 (.clk(clk), .rst(rst), .bus(bus));
  decode_operand_stage #(.XLEN(32), .BYPASS_EN(1'b0)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus1.in_valid  = bus.in_valid;
  assign bus1.in_instr  = bus.in_instr;
  assign bus1.in_pc     = bus.in_pc;
  assign bus1.flush     = bus.flush;
  assign bus1.wb_en     = bus.wb_en;
  assign bus1.wb_rd     = bus.wb_rd;
  assign bus1.wb_data   = bus.wb_data;
  assign bus1.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  func;
    logic        ctrl;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[12];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every accepted bundle must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_bundle: got A=%h B=%h rd=%0d with nothing expected",
                 bus.alu_in_A, bus.alu_in_B, bus.out_rd);
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        if (bus.alu_in_A !== e.a || bus.alu_in_B !== e.b || bus.func !== e.func ||
            bus.control !== e.ctrl || bus.out_rd !== e.rd || bus.out_rd_we !== e.we ||
            bus.out_illegal !== e.ill) begin
          fails++;
          $display("FAIL bundle instr=%h: got A=%h B=%h f=%0d c=%0b rd=%0d we=%0b ill=%0b expected A=%h B=%h f=%0d c=%0b rd=%0d we=%0b ill=%0b",
                   e.instr, bus.alu_in_A, bus.alu_in_B, bus.func, bus.control, bus.out_rd,
                   bus.out_rd_we, bus.out_illegal, e.a, e.b, e.func, e.ctrl, e.rd, e.we, e.ill);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v, input bit track);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = v.instr;
    bus.in_pc    = v.pc;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.in_ready) begin
        if (track) sb_q.push_back(v);
        done = 1'b1;
      end
      tick();
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: instr %h not accepted within 20 cycles", v.instr);
    end
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = rd;
    bus.wb_data = data;
    tick();
    bus.wb_en = 1'b0;
  endtask

  initial begin
    vec_t v;
    tbl[0]  = '{32'h00500093, 32'h0, 32'h00000000, 32'h00000005, 3'd0, 1'b0, 5'd1,  1'b1, 1'b0};
    tbl[1]  = '{32'h12345137, 32'h0, 32'h12345000, 32'h00000000, 3'd0, 1'b1, 5'd2,  1'b1, 1'b0};
    tbl[2]  = '{32'hABCDE317, 32'h00001000, 32'h00001000, 32'hABCDE000, 3'd0, 1'b0, 5'd6, 1'b1, 1'b0};
    tbl[3]  = '{32'h40208033, 32'h0, 32'h00000000, 32'h00000000, 3'd0, 1'b0, 5'd0,  1'b0, 1'b1};
    tbl[4]  = '{32'hFFF00393, 32'h0, 32'h00000000, 32'hFFFFFFFF, 3'd0, 1'b0, 5'd7,  1'b1, 1'b0};
    tbl[5]  = '{32'h40109093, 32'h0, 32'h00000000, 32'h00000000, 3'd0, 1'b0, 5'd1,  1'b0, 1'b1};
    tbl[6]  = '{32'h7FF02413, 32'h0, 32'h00000000, 32'h000007FF, 3'd2, 1'b0, 5'd8,  1'b1, 1'b0};
    tbl[7]  = '{32'h00000033, 32'h0, 32'h00000000, 32'h00000000, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0};
    tbl[8]  = '{32'h0000006F, 32'h0, 32'h00000000, 32'h00000000, 3'd0, 1'b0, 5'd0,  1'b0, 1'b1};
    tbl[9]  = '{32'h4030D293, 32'h0, 32'h80000000, 32'h00000003, 3'd5, 1'b1, 5'd5,  1'b1, 1'b0};
    tbl[10] = '{32'h4000D633, 32'h0, 32'h80000000, 32'h00000000, 3'd5, 1'b1, 5'd12, 1'b1, 1'b0};
    tbl[11] = '{32'h01F0D693, 32'h0, 32'h80000000, 32'h0000001F, 3'd5, 1'b0, 5'd13, 1'b1, 1'b0};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0; bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_outputs", {bus.alu_in_A | bus.alu_in_B}, 32'h0);
    chk("rst_ctrl_fields", 32'({bus.func, bus.control, bus.out_rd, bus.out_rd_we, bus.out_illegal}), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    rst = 1'b0;
    tick();

    wb_write(5'd1, 32'h80000000);
    foreach (tbl[i]) send(tbl[i], 1'b1);
    bus.in_valid = 1'b0;
    tick(); tick();

    // Bypass: writeback and capture in the same cycle.
    bus.in_valid = 1'b1; bus.in_instr = 32'h00318233;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hDEADBEEF;
    chk("byp_in_ready", 32'(bus.in_ready), 32'h1);
    v = '{32'h00318233, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 3'd0, 1'b0, 5'd4, 1'b1, 1'b0};
    sb_q.push_back(v);
    tick();
    bus.wb_en = 1'b0; bus.in_valid = 1'b0;
    chk("nobyp_valid", 32'(bus1.out_valid), 32'h1);
    chk("nobyp_A", bus1.alu_in_A, 32'h0);
    chk("nobyp_B", bus1.alu_in_B, 32'h0);
    tick(); tick();

    // Stall for 3 cycles; a writeback during the hold must not alter the held operands.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h003184B3;
    chk("stall_cap_ready", 32'(bus.in_ready), 32'h1);
    v = '{32'h003184B3, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 3'd0, 1'b0, 5'd9, 1'b1, 1'b0};
    sb_q.push_back(v);
    tick();
    bus.in_instr = tbl[1].instr;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", 32'(bus.in_ready), 32'h0);
      chk("stall_valid", 32'(bus.out_valid), 32'h1);
      chk("stall_A", bus.alu_in_A, 32'hDEADBEEF);
      chk("stall_B", bus.alu_in_B, 32'hDEADBEEF);
      tick();
      bus.wb_en = 1'b0;
    end
    sb_q.push_back(tbl[1]);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("no_bubble_valid", 32'(bus.out_valid), 32'h1);
    chk("no_bubble_A", bus.alu_in_A, 32'h12345000);
    tick(); tick();

    // Flush of a held bundle, then flush colliding with a capture.
    v = '{32'h00008513, 32'h0, 32'h80000000, 32'h0, 3'd0, 1'b0, 5'd10, 1'b1, 1'b0};
    bus.out_ready = 1'b0;
    send(v, 1'b0);
    bus.in_valid = 1'b0;
    chk("hold_valid", 32'(bus.out_valid), 32'h1);
    bus.flush = 1'b1;
    chk("flush_in_ready_hold", 32'(bus.in_ready), 32'h0);
    tick();
    bus.flush = 1'b0;
    chk("flush_valid", 32'(bus.out_valid), 32'h0);
    bus.flush = 1'b1; bus.in_valid = 1'b1;
    chk("flush_in_ready_idle", 32'(bus.in_ready), 32'h1);
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_beats_capture", 32'(bus.out_valid), 32'h0);

    // Asynchronous reset in the middle of a hold clears the bundle and the register file.
    send(v, 1'b0);
    bus.in_valid = 1'b0;
    chk("hold2_valid", 32'(bus.out_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst_A", bus.alu_in_A, 32'h0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    v = '{32'h001085B3, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 5'd11, 1'b1, 1'b0};
    send(v, 1'b1);
    bus.in_valid = 1'b0;
    tick(); tick(); tick();

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
